// File: rtl/latch_bank_arb.sv
// latch_bank_arb
//
// Round-robin arbiter and write sequencer sharing one bank of NWORD
// transparent latches (DW bits per word) between NREQ synchronous
// requesters. Each granted write becomes a SETUP / OPEN / HOLD sequence on
// the latch D, GE, G pins, so D and GE are always stable around the G pulse.
// An optional bulk clear pulses every latch CLR pin for one cycle.
//
// Optional feature macro: LATCH_BANK_ARB_CLR_EN
//   defined   : CLR_ALL, the pending-clear flag and the CLEAR state are built.
//   undefined : CLR_ALL is ignored; LAT_CLR is all ones in reset, 0 otherwise.
//
// Ports
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   REQ        in   [NREQ]     per-requester write request (level)
//   ADDR       in   [NREQ*AW]  per-requester word address, slice i = req i
//   DATA       in   [NREQ*DW]  per-requester write data, slice i = req i
//   GNT        out  [NREQ]     one-hot, one-cycle grant pulse
//   CLR_ALL    in   one-cycle bulk clear request
//   BUSY       out  high whenever the FSM is not in IDLE
//   LAT_D      out  [DW]       data to all latch D pins
//   LAT_GE     out  [NWORD]    one-hot gate enable of the selected word
//   LAT_G      out  common latch gate
//   LAT_CLR    out  [NWORD]    per-word asynchronous clear
//   dbg_state  out  [3]        current FSM state
//                              (0 IDLE, 1 SETUP, 2 OPEN, 3 HOLD, 4 CLEAR)
//
// Handshake: REQ[i] acts as a valid that the requester holds, together with
// ADDR/DATA slice i, until GNT[i] pulses; GNT[i] is the one-cycle ready and
// the transfer happens in that cycle. The requester may drop REQ[i] or start
// a new write from the cycle after GNT[i]. Dropping REQ before a grant
// withdraws the request.

module latch_bank_arb #(
   parameter int NREQ  = 4,
   parameter int NWORD = 8,
   parameter int AW    = 3,
   parameter int DW    = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*AW-1:0] ADDR,
   input  logic [NREQ*DW-1:0] DATA,
   output logic [NREQ-1:0]    GNT,
   input  logic               CLR_ALL,
   output logic               BUSY,
   output logic [DW-1:0]      LAT_D,
   output logic [NWORD-1:0]   LAT_GE,
   output logic               LAT_G,
   output logic [NWORD-1:0]   LAT_CLR,
   output logic [2:0]         dbg_state
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_OPEN  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef LATCH_BANK_ARB_CLR_EN
   localparam logic [2:0] S_CLEAR = 3'd4;
`endif

   logic [2:0]       state;
   logic [PW-1:0]    ptr;

   logic [PW-1:0]    win;
   logic             win_vld;
   logic [PW:0]      arb_sum;
   logic [PW-1:0]    arb_idx;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic [NWORD-1:0] ge_dec;
   logic [NREQ-1:0]  gnt_dec;

   assign dbg_state = state;

   // Round-robin search: the first set REQ bit at or above ptr, wrapping
   // modulo NREQ. The sum is one bit wider so the wrap works for any NREQ,
   // not only powers of two.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      arb_sum = '0;
      arb_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         arb_sum = {1'b0, ptr} + (PW+1)'(k);
         if (arb_sum >= (PW+1)'(NREQ)) begin
            arb_sum = arb_sum - (PW+1)'(NREQ);
         end
         arb_idx = arb_sum[PW-1:0];
         if (!win_vld && REQ[arb_idx]) begin
            win     = arb_idx;
            win_vld = 1'b1;
         end
      end
   end

   // Winner's address/data and the decoded gate enable. Addresses at or
   // beyond NWORD match no word, so the write is sequenced with GE all-zero.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      gnt_dec  = '0;
      ge_dec   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            sel_addr   = ADDR[i*AW +: AW];
            sel_data   = DATA[i*DW +: DW];
            gnt_dec[i] = win_vld;
         end
      end
      for (int j = 0; j < NWORD; j++) begin
         if (sel_addr == AW'(j)) begin
            ge_dec[j] = 1'b1;
         end
      end
   end

`ifdef LATCH_BANK_ARB_CLR_EN
   // Clear requests seen while busy are remembered; any number of pulses
   // collapse into one CLEAR taken at the next IDLE cycle.
   logic pend;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend <= 1'b0;
      end else if (state == S_IDLE) begin
         pend <= 1'b0;
      end else if (CLR_ALL) begin
         pend <= 1'b1;
      end
   end
`else
   logic unused_clr_all;
   assign unused_clr_all = CLR_ALL;
`endif

   // All outputs are registered. LAT_D/LAT_GE only change on entry to SETUP
   // and on exit from HOLD, both cycles where LAT_G is low, so the latch
   // never sees D or GE move while it is transparent.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         ptr     <= '0;
         GNT     <= '0;
         BUSY    <= 1'b0;
         LAT_D   <= '0;
         LAT_GE  <= '0;
         LAT_G   <= 1'b0;
         LAT_CLR <= '1;
      end else begin
         GNT     <= '0;
         LAT_CLR <= '0;
         case (state)
            S_IDLE: begin
`ifdef LATCH_BANK_ARB_CLR_EN
               if (CLR_ALL || pend) begin
                  state   <= S_CLEAR;
                  BUSY    <= 1'b1;
                  LAT_CLR <= '1;
               end else
`endif
               if (win_vld) begin
                  state  <= S_SETUP;
                  BUSY   <= 1'b1;
                  GNT    <= gnt_dec;
                  LAT_D  <= sel_data;
                  LAT_GE <= ge_dec;
                  ptr    <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
               end
            end
            S_SETUP: begin
               state <= S_OPEN;
               LAT_G <= 1'b1;
            end
            S_OPEN: begin
               state <= S_HOLD;
               LAT_G <= 1'b0;
            end
            S_HOLD: begin
               state  <= S_IDLE;
               BUSY   <= 1'b0;
               LAT_GE <= '0;
            end
`ifdef LATCH_BANK_ARB_CLR_EN
            S_CLEAR: begin
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end
`endif
            default: begin
               state  <= S_IDLE;
               BUSY   <= 1'b0;
               LAT_G  <= 1'b0;
               LAT_GE <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_bank_arb.sv
// Testbench for latch_bank_arb (NREQ=4, NWORD=6, AW=3, DW=8 so that
// addresses 6 and 7 are out of range). Expectations come from a round-robin
// reference model (rr_pick) and the cycle latencies of the write sequence.

module tb_latch_bank_arb;

   localparam int NREQ  = 4;
   localparam int NWORD = 6;
   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int WAIT_MAX = 4*NREQ + 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req     = '0;
   logic [NREQ*AW-1:0] addr    = '0;
   logic [NREQ*DW-1:0] data    = '0;
   logic               clr_all = 1'b0;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [DW-1:0]      lat_d;
   logic [NWORD-1:0]   lat_ge;
   logic               lat_g;
   logic [NWORD-1:0]   lat_clr;
   logic [2:0]         dbg_state;

   latch_bank_arb #(.NREQ(NREQ), .NWORD(NWORD), .AW(AW), .DW(DW)) dut (
      .CLK(clk), .RST_N(rst_n), .REQ(req), .ADDR(addr), .DATA(data),
      .GNT(gnt), .CLR_ALL(clr_all), .BUSY(busy), .LAT_D(lat_d),
      .LAT_GE(lat_ge), .LAT_G(lat_g), .LAT_CLR(lat_clr),
      .dbg_state(dbg_state)
   );

   int vectors    = 0;
   int miscompares = 0;
   int m_ptr      = 0;

   localparam logic [NWORD-1:0] ALL_ONES = {NWORD{1'b1}};

   // ---------------- reference model ----------------
   function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         int idx = (ptr + k) % NREQ;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int w);
      logic [NREQ-1:0] v = '0;
      if (w >= 0) v[w] = 1'b1;
      return v;
   endfunction

   function automatic logic [NWORD-1:0] ge_of(input int a);
      logic [NWORD-1:0] v = '0;
      if (a >= 0 && a < NWORD) v[a] = 1'b1;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int i, input int a, input int d);
      addr[i*AW +: AW] = AW'(a);
      data[i*DW +: DW] = DW'(d);
   endtask

   task automatic do_reset();
      req = '0; clr_all = 1'b0; addr = '0; data = '0;
      #1 rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      m_ptr = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      tick();
      while (busy !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      req = '0; clr_all = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b required 0", gnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
      vectors++; if (lat_d !== '0) begin miscompares++; $display("FAIL reset_lat_d: got %h required 0", lat_d); end
      vectors++; if (lat_ge !== '0) begin miscompares++; $display("FAIL reset_lat_ge: got %b required 0", lat_ge); end
      vectors++; if (lat_g !== 1'b0) begin miscompares++; $display("FAIL reset_lat_g: got %b required 0", lat_g); end
      vectors++; if (lat_clr !== ALL_ONES) begin miscompares++; $display("FAIL reset_lat_clr: got %b required %b", lat_clr, ALL_ONES); end
      vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
      tick();
      vectors++; if (lat_clr !== ALL_ONES) begin miscompares++; $display("FAIL reset_hold_clr: got %b required %b", lat_clr, ALL_ONES); end
      rst_n = 1'b1;
      m_ptr = 0;
      tick();
      vectors++; if (lat_clr !== '0) begin miscompares++; $display("FAIL reset_release_clr: got %b required 0", lat_clr); end
      vectors++; if (gnt !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_idle: gnt=%b busy=%b required 0/0", gnt, busy); end
   endtask

   task automatic test_single_write();
      logic [NREQ-1:0] exp_gnt;
      do_reset(); tick();
      set_wr(2, 5, 8'hA5);
      req = 4'b0100;
      exp_gnt = onehot(rr_pick(m_ptr, req));
      m_ptr = (rr_pick(m_ptr, req) + 1) % NREQ;
      tick();
      req = '0;
      vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL single_gnt: got %b required %b", gnt, exp_gnt); end
      vectors++; if (lat_ge !== ge_of(5) || lat_d !== 8'hA5 || lat_g !== 1'b0) begin miscompares++; $display("FAIL single_setup: ge=%b d=%h g=%b required %b/a5/0", lat_ge, lat_d, lat_g, ge_of(5)); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b required 1", busy); end
      tick();
      vectors++; if (lat_g !== 1'b1 || lat_ge !== ge_of(5) || lat_d !== 8'hA5 || gnt !== '0) begin miscompares++; $display("FAIL single_open: g=%b ge=%b d=%h gnt=%b required 1/%b/a5/0", lat_g, lat_ge, lat_d, gnt, ge_of(5)); end
      tick();
      vectors++; if (lat_g !== 1'b0 || lat_ge !== ge_of(5) || lat_d !== 8'hA5) begin miscompares++; $display("FAIL single_hold: g=%b ge=%b d=%h required 0/%b/a5", lat_g, lat_ge, lat_d, ge_of(5)); end
      tick();
      vectors++; if (lat_ge !== '0 || lat_d !== 8'hA5 || busy !== 1'b0 || lat_g !== 1'b0) begin miscompares++; $display("FAIL single_idle: ge=%b d=%h busy=%b g=%b required 0/a5/0/0", lat_ge, lat_d, busy, lat_g); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      int w, last, cyc, n;
      do_reset(); tick();
      for (int i = 0; i < NREQ; i++) set_wr(i, $urandom_range(0, NWORD-1), $urandom_range(0, 255));
      req = '1;
      for (int g = 0; g < 5; g++) begin
         w = rr_pick(m_ptr, req);
         exp_q.push_back(8'(w));
         m_ptr = (w + 1) % NREQ;
      end
      last = -1; cyc = 0; n = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         tick();
         cyc++;
         if (gnt !== '0) begin
            w = int'(exp_q.pop_front());
            n++;
            if (exp_q.size() == 0) req = '0;
            vectors++; if (gnt !== onehot(w)) begin miscompares++; $display("FAIL b2b_order%0d: got %b required %b", n, gnt, onehot(w)); end
            vectors++; if (lat_d !== data[w*DW +: DW] || lat_ge !== ge_of(int'(addr[w*AW +: AW]))) begin miscompares++; $display("FAIL b2b_payload%0d: d=%h ge=%b required %h/%b", n, lat_d, lat_ge, data[w*DW +: DW], ge_of(int'(addr[w*AW +: AW]))); end
            if (last >= 0) begin
               vectors++; if (cyc - last != 4) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d required 4", n, cyc - last); end
            end
            last = cyc;
         end
      end
      req = '0;
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_timeout: %0d grants missing, required 0", exp_q.size()); end
      wait_idle();
   endtask

   task automatic test_ptr_wrap();
      logic [NREQ-1:0] pat [3];
      int w, n;
      pat[0] = 4'b0010; pat[1] = 4'b0011; pat[2] = 4'b0011;
      do_reset(); tick();
      for (int i = 0; i < NREQ; i++) set_wr(i, i, 16 * i + 1);
      for (int s = 0; s < 3; s++) begin
         req = pat[s];
         w = rr_pick(m_ptr, req);
         n = 0;
         tick();
         while (gnt === '0 && n < 10) begin tick(); n++; end
         req = '0;
         vectors++; if (gnt !== onehot(w)) begin miscompares++; $display("FAIL ptr_step%0d: got %b required %b", s, gnt, onehot(w)); end
         m_ptr = (w + 1) % NREQ;
      end
      wait_idle();
   endtask

   task automatic test_clear();
      logic [NREQ-1:0] exp_gnt;
      do_reset(); tick();
      set_wr(0, 3, 8'h3C);
      set_wr(3, 1, 8'hC3);
      req = 4'b0001;
      exp_gnt = onehot(rr_pick(m_ptr, req));
      m_ptr = (rr_pick(m_ptr, req) + 1) % NREQ;
      tick();                                               // SETUP
      vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL clr_first_gnt: got %b required %b", gnt, exp_gnt); end
      req = 4'b1000;
      exp_gnt = onehot(rr_pick(m_ptr, req));
      m_ptr = (rr_pick(m_ptr, req) + 1) % NREQ;
      tick();                                               // OPEN
      vectors++; if (lat_g !== 1'b1) begin miscompares++; $display("FAIL clr_open: lat_g=%b required 1", lat_g); end
      clr_all = 1'b1;
      tick();                                               // HOLD
      clr_all = 1'b0;
      vectors++; if (lat_clr !== '0 || lat_g !== 1'b0) begin miscompares++; $display("FAIL clr_hold: clr=%b g=%b required 0/0", lat_clr, lat_g); end
      tick();                                               // IDLE
      vectors++; if (busy !== 1'b0 || lat_clr !== '0 || lat_ge !== '0) begin miscompares++; $display("FAIL clr_idle: busy=%b clr=%b ge=%b required 0/0/0", busy, lat_clr, lat_ge); end
      tick();
`ifdef LATCH_BANK_ARB_CLR_EN
      vectors++; if (lat_clr !== ALL_ONES || gnt !== '0 || lat_g !== 1'b0 || lat_ge !== '0) begin miscompares++; $display("FAIL clr_pulse: clr=%b gnt=%b g=%b ge=%b required %b/0/0/0", lat_clr, gnt, lat_g, lat_ge, ALL_ONES); end
      tick();
      vectors++; if (lat_clr !== '0 || gnt !== '0) begin miscompares++; $display("FAIL clr_after: clr=%b gnt=%b required 0/0", lat_clr, gnt); end
      tick();
`else
      vectors++; if (lat_clr !== '0) begin miscompares++; $display("FAIL clr_disabled: clr=%b required 0", lat_clr); end
`endif
      req = '0;
      vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL clr_pending_gnt: got %b required %b", gnt, exp_gnt); end
      vectors++; if (lat_d !== 8'hC3 || lat_ge !== ge_of(1)) begin miscompares++; $display("FAIL clr_pending_payload: d=%h ge=%b required c3/%b", lat_d, lat_ge, ge_of(1)); end
      wait_idle();

      // Clear and request in the same IDLE cycle: the clear goes first.
      set_wr(1, 2, 8'h5E);
      req = 4'b0010;
      clr_all = 1'b1;
      exp_gnt = onehot(rr_pick(m_ptr, req));
      m_ptr = (rr_pick(m_ptr, req) + 1) % NREQ;
      tick();
      clr_all = 1'b0;
`ifdef LATCH_BANK_ARB_CLR_EN
      vectors++; if (lat_clr !== ALL_ONES || gnt !== '0) begin miscompares++; $display("FAIL clr_same_pulse: clr=%b gnt=%b required %b/0", lat_clr, gnt, ALL_ONES); end
      tick(); tick();
`else
      vectors++; if (lat_clr !== '0) begin miscompares++; $display("FAIL clr_same_disabled: clr=%b required 0", lat_clr); end
`endif
      req = '0;
      vectors++; if (gnt !== exp_gnt || lat_d !== 8'h5E) begin miscompares++; $display("FAIL clr_same_gnt: gnt=%b d=%h required %b/5e", gnt, lat_d, exp_gnt); end
      wait_idle();
   endtask

   task automatic test_out_of_range();
      int addrs [3];
      int w;
      logic [NREQ-1:0] r;
      addrs[0] = 6; addrs[1] = 7; addrs[2] = NWORD - 1;
      do_reset(); tick();
      for (int t = 0; t < 3; t++) begin
         r = onehot(t + 1);
         set_wr(t + 1, addrs[t], 8'h50 + t);
         req = r;
         w = rr_pick(m_ptr, r);
         m_ptr = (w + 1) % NREQ;
         tick();
         req = '0;
         vectors++; if (gnt !== onehot(w) || lat_ge !== ge_of(addrs[t]) || lat_d !== DW'(8'h50 + t)) begin miscompares++; $display("FAIL oob_setup_a%0d: gnt=%b ge=%b d=%h required %b/%b/%h", addrs[t], gnt, lat_ge, lat_d, onehot(w), ge_of(addrs[t]), 8'h50 + t); end
         tick();
         vectors++; if (lat_g !== 1'b1 || lat_ge !== ge_of(addrs[t])) begin miscompares++; $display("FAIL oob_open_a%0d: g=%b ge=%b required 1/%b", addrs[t], lat_g, lat_ge, ge_of(addrs[t])); end
         tick();
         vectors++; if (lat_g !== 1'b0 || lat_ge !== ge_of(addrs[t])) begin miscompares++; $display("FAIL oob_hold_a%0d: g=%b ge=%b required 0/%b", addrs[t], lat_g, lat_ge, ge_of(addrs[t])); end
         tick();
         vectors++; if (busy !== 1'b0 || lat_ge !== '0) begin miscompares++; $display("FAIL oob_idle_a%0d: busy=%b ge=%b required 0/0", addrs[t], busy, lat_ge); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(); tick();
      set_wr(2, 4, 8'h77);
      req = 4'b0100;
      tick();
      req = '0;
      vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL mid_gnt: got %b required 0100", gnt); end
      tick();
      vectors++; if (lat_g !== 1'b1) begin miscompares++; $display("FAIL mid_open: lat_g=%b required 1", lat_g); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (lat_g !== 1'b0 || lat_clr !== ALL_ONES) begin miscompares++; $display("FAIL mid_reset_async: g=%b clr=%b required 0/%b", lat_g, lat_clr, ALL_ONES); end
      vectors++; if (lat_ge !== '0 || lat_d !== '0 || busy !== 1'b0 || gnt !== '0) begin miscompares++; $display("FAIL mid_reset_vals: ge=%b d=%h busy=%b gnt=%b required 0", lat_ge, lat_d, busy, gnt); end
      tick();
      rst_n = 1'b1;
      m_ptr = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++; if (gnt !== '0 || lat_g !== 1'b0 || lat_clr !== '0) begin miscompares++; $display("FAIL mid_after%0d: gnt=%b g=%b clr=%b required 0/0/0", c, gnt, lat_g, lat_clr); end
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0]  cur_req, prev_req, exp_gnt;
      logic [NWORD-1:0] cur_ge, exp_ge;
      logic [DW-1:0]    last_d;
      int a_q [NREQ];
      int d_q [NREQ];
      int wait_cnt [NREQ];
      int granted_at [NREQ];
      int last_gnt, w;
      bit any_gnt;
      do_reset(); tick();
      cur_req = '0; last_gnt = -100; any_gnt = 1'b0; last_d = '0; cur_ge = '0;
      for (int i = 0; i < NREQ; i++) begin
         a_q[i] = 0; d_q[i] = 0; wait_cnt[i] = 0; granted_at[i] = -10;
      end
      for (int k = 0; k < 400; k++) begin
         prev_req = cur_req;
         tick();
         if (gnt !== '0) begin
            w = rr_pick(m_ptr, prev_req);
            exp_gnt = onehot(w);
            vectors++; if (gnt !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt@%0d: got %b required %b (req %b)", k, gnt, exp_gnt, prev_req); end
            vectors++; if (any_gnt && k - last_gnt < 4) begin miscompares++; $display("FAIL rnd_spacing@%0d: got %0d required >=4", k, k - last_gnt); end
            if (w >= 0) begin
               vectors++; if (wait_cnt[w] > WAIT_MAX) begin miscompares++; $display("FAIL rnd_wait@%0d: req %0d waited %0d required <=%0d", k, w, wait_cnt[w], WAIT_MAX); end
               m_ptr = (w + 1) % NREQ;
               granted_at[w] = k;
               wait_cnt[w] = 0;
               last_d = DW'(d_q[w]);
               cur_ge = ge_of(a_q[w]);
            end
            last_gnt = k;
            any_gnt = 1'b1;
         end
         if (any_gnt) begin
            exp_ge = (k - last_gnt <= 2) ? cur_ge : '0;
            vectors++; if (lat_g !== (k == last_gnt + 1)) begin miscompares++; $display("FAIL rnd_lat_g@%0d: got %b required %b", k, lat_g, (k == last_gnt + 1)); end
            vectors++; if (lat_ge !== exp_ge) begin miscompares++; $display("FAIL rnd_lat_ge@%0d: got %b required %b", k, lat_ge, exp_ge); end
            vectors++; if (lat_d !== last_d) begin miscompares++; $display("FAIL rnd_lat_d@%0d: got %h required %h", k, lat_d, last_d); end
         end
         vectors++; if (lat_g === 1'b1 && lat_clr !== '0) begin miscompares++; $display("FAIL rnd_g_clr@%0d: g=%b clr=%b required not both", k, lat_g, lat_clr); end
         for (int i = 0; i < NREQ; i++) begin
            if (cur_req[i]) begin
               if (granted_at[i] == k - 1) begin
                  if (k < 300 && $urandom_range(0, 1) == 1) begin
                     a_q[i] = $urandom_range(0, 7);
                     d_q[i] = $urandom_range(0, 255);
                     set_wr(i, a_q[i], d_q[i]);
                     wait_cnt[i] = 0;
                  end else begin
                     cur_req[i] = 1'b0;
                  end
               end else if (granted_at[i] != k) begin
                  wait_cnt[i]++;
               end
            end else if (k < 300 && $urandom_range(0, 2) == 0) begin
               a_q[i] = $urandom_range(0, 7);
               d_q[i] = $urandom_range(0, 255);
               set_wr(i, a_q[i], d_q[i]);
               cur_req[i] = 1'b1;
               wait_cnt[i] = 0;
            end
         end
         req = cur_req;
      end
      vectors++; if (cur_req !== '0) begin miscompares++; $display("FAIL rnd_drain: pending %b required 0", cur_req); end
      req = '0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_ptr_wrap();
      test_clear();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/latch_bank_arb.md
# latch_bank_arb

Round-robin arbiter and sequencer that shares one bank of NWORD LDCE-style transparent latches (DW bits per word) between NREQ synchronous requesters. It turns each granted write into a glitch-safe SETUP/OPEN/HOLD sequence on the latch D, GE, G and CLR pins. D and GE are therefore always stable around the G pulse. It sits between clocked fabric logic and latch-based storage inside Verilator-simulated Xilinx primitive netlists.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NWORD, 8, number of latch words in the bank
- AW, 3, word address width; NWORD ≤ 2^AW
- DW, 8, data width per word

Ports:
- CLK  input  1  single clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- REQ  input  NREQ  per-requester write request, level, held until granted
- ADDR  input  NREQ*AW  per-requester word address, slice i = requester i
- DATA  input  NREQ*DW  per-requester write data
- GNT  output  NREQ  one-hot, one-cycle grant pulse
- CLR_ALL  input  1  one-cycle bulk-clear request
- BUSY  output  1  high when the FSM is not in IDLE
- LAT_D  output  DW  data to all latch D pins
- LAT_GE  output  NWORD  one-hot gate enable for the selected word
- LAT_G  output  1  common latch gate
- LAT_CLR  output  NWORD  per-word asynchronous clear

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD, CLEAR. All outputs are registered.
- IDLE:
  - A pending clear goes to CLEAR and has priority.
  - Otherwise, if any REQ bit is set, pick a winner round-robin and go to SETUP.
- Round-robin: search starts at index PTR and proceeds upward modulo NREQ. After a grant to requester w, PTR becomes (w+1) mod NREQ.
- SETUP:
  - GNT[w] pulses high.
  - LAT_D is set to DATA[w].
  - LAT_GE is set to 1 << ADDR[w], decoded from the ADDR and DATA values captured on entry.
  - LAT_G stays low. Next state is OPEN.
- OPEN: LAT_G is high. LAT_D and LAT_GE are unchanged. Next state is HOLD.
- HOLD:
  - LAT_G goes low, and LAT_D and LAT_GE are held for this cycle.
  - Then LAT_GE returns to 0 and the FSM goes to IDLE. LAT_D keeps its last value.
- Out-of-range address (ADDR ≥ NWORD):
  - The write is still granted and sequenced.
  - LAT_GE stays all-zero, so no word is written.
- CLEAR:
  - LAT_CLR is all ones for exactly one cycle. LAT_G and LAT_GE stay 0.
  - Next state is IDLE. PTR is unchanged.
- CLR_ALL arriving while the FSM is not in IDLE is latched into a pending flag. Multiple pulses merge into one clear.
- A requester dropping REQ before its grant simply drops out. No grant is issued to an idle requester.

## Timing
- Reset values:
  - FSM is in IDLE, PTR = 0, pending clear = 0.
  - GNT = 0, BUSY = 0, LAT_D = 0, LAT_GE = 0, LAT_G = 0.
  - LAT_CLR = all ones, so the bank is cleared during reset. LAT_CLR drops to 0 on the first clock edge after RST_N deasserts.
- Latency: REQ seen high in IDLE at edge n gives GNT and SETUP outputs at edge n+1, LAT_G high at n+2, LAT_G low at n+3, and IDLE at n+4.
- Throughput: one write per 4 cycles. A new arbitration happens on the IDLE cycle.
- LAT_G is never high in a cycle where LAT_D or LAT_GE changes. LAT_G and LAT_CLR are never high together.
- Requester protocol: REQ, ADDR and DATA stay stable until GNT is seen. REQ may be deasserted or re-asserted for a new write the cycle after GNT.
- If CLR_ALL and REQ arrive in the same IDLE cycle, CLEAR runs first and the write follows.
- RST_N asserted mid-sequence forces reset values immediately, including LAT_G low, with no HOLD cycle.

## Configuration
- Macro: LATCH_BANK_ARB_CLR_EN.
- Defined: the CLR_ALL, pending-flag and CLEAR-state behaviour is exactly as described above.
- Undefined:
  - CLR_ALL is ignored and the CLEAR state and pending flag are not built.
  - LAT_CLR is still all ones during reset and 0 otherwise.

## Test plan
- Reset then release; single REQ[2], ADDR=5, DATA=0xA5 -> GNT[2] at +1; LAT_GE=0x20 and LAT_D=0xA5 from +1 to +3; LAT_G high only at +2; IDLE at +4.
- REQ=4'b1111 held, re-asserted after each grant -> grant order 0,1,2,3,0; each write 4 cycles apart.
- PTR=2 with REQ=4'b0011 -> GNT[0] first; PTR becomes 1.
- CLR_ALL pulsed during the OPEN cycle of a write -> write completes; LAT_CLR=0xFF for one cycle right after IDLE; pending REQ is served next. With the macro undefined, LAT_CLR stays 0.
- ADDR=7 with NWORD=6 -> GNT issued and LAT_G pulses, but LAT_GE stays 0.
- RST_N dropped while LAT_G=1 -> LAT_G=0 and LAT_CLR=all ones immediately; after release, no stale GNT.
